// File: rtl/iram_access_ctrl.sv
// Instruction RAM side-port arbiter: stalls and drains the CPU, then sequences monitor reads/writes; flushes and optionally restarts the CPU on release.
// Latency: grant DRAIN_CYCLES+1 cycles after mon_own; write ack 2 cycles, read ack 3 cycles after mon_valid.
// Backpressure: one outstanding access; mon_valid outside OWN is dropped, and the monitor waits for mon_ack before strobing again.
module iram_access_ctrl #(
    parameter int ADR_W        = 12,
    parameter int DRAIN_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mon_own,
    input  logic             mon_valid,
    input  logic             mon_we,
    input  logic [ADR_W-1:0] mon_adr,
    input  logic [31:0]      mon_wdata,
    input  logic             mon_run,
    input  logic [29:0]      mon_start_adr,
    output logic             mon_ack,
    output logic [31:0]      mon_rdata,
    output logic             mon_granted,
    output logic [ADR_W-1:0] i_ram_radr,
    input  logic [31:0]      i_ram_rdata,
    output logic [ADR_W-1:0] i_ram_wadr,
    output logic [31:0]      i_ram_wdata,
    output logic             i_ram_wen,
    output logic             i_read_sel,
    output logic             cpu_stall,
    output logic             rst_pipe,
    output logic             cpu_start,
    output logic [29:0]      start_adr
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRAIN,
        S_OWN,
        S_ACC,
        S_RD,
        S_REL
    } state_t;

    localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYCLES - 1);

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             latch;
    logic             we_q;
    logic [ADR_W-1:0] adr_q;
    logic [31:0]      wdata_q;
    logic             ack_q;
    logic [31:0]      rdata_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        latch   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (mon_own) begin
                    state_d = S_DRAIN;
                    cnt_d   = DRAIN_INIT;
                end
            end
            S_DRAIN: begin
                if (!mon_own)
                    state_d = S_IDLE;
                else if (cnt_q == 4'd0)
                    state_d = S_OWN;
                else
                    cnt_d = cnt_q - 4'd1;
            end
            S_OWN: begin
                // A strobe wins over a simultaneous release; REL follows once the ack is out.
                if (mon_valid) begin
                    latch   = 1'b1;
                    state_d = S_ACC;
                end else if (!mon_own) begin
                    state_d = S_REL;
                end
            end
            S_ACC:   state_d = we_q ? S_OWN : S_RD;
            S_RD:    state_d = S_OWN;
            S_REL:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            adr_q   <= '0;
            wdata_q <= '0;
            ack_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (latch) begin
                we_q    <= mon_we;
                adr_q   <= mon_adr;
                wdata_q <= mon_wdata;
            end
            ack_q <= ((state_q == S_ACC) && we_q) || (state_q == S_RD);
            // RAM data for the address presented in ACC arrives during RD.
            if (state_q == S_RD)
                rdata_q <= i_ram_rdata;
        end
    end

    assign mon_ack     = ack_q;
    assign mon_rdata   = rdata_q;
    assign mon_granted = (state_q == S_OWN) || (state_q == S_ACC) || (state_q == S_RD);
    assign i_read_sel  = mon_granted;
    assign i_ram_radr  = adr_q;
    assign i_ram_wadr  = adr_q;
    assign i_ram_wdata = wdata_q;
    assign i_ram_wen   = (state_q == S_ACC) && we_q;
    assign cpu_stall   = (state_q != S_IDLE);
    assign rst_pipe    = (state_q == S_REL);
    assign cpu_start   = (state_q == S_REL) && mon_run;
    assign start_adr   = cpu_start ? mon_start_adr : '0;

endmodule

// File: tb/tb_iram_access_ctrl.sv
// Bench for iram_access_ctrl: table vectors, hand-written ownership/protocol sequences and random accesses checked against a reference memory.
module tb_iram_access_ctrl;
    localparam int ADR_W = 12;
    localparam int DRAIN = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             mon_own, mon_valid, mon_we, mon_run;
    logic [ADR_W-1:0] mon_adr;
    logic [31:0]      mon_wdata;
    logic [29:0]      mon_start_adr;
    logic             mon_ack, mon_granted, i_ram_wen, i_read_sel;
    logic             cpu_stall, rst_pipe, cpu_start;
    logic [31:0]      mon_rdata, i_ram_rdata, i_ram_wdata;
    logic [ADR_W-1:0] i_ram_radr, i_ram_wadr;
    logic [29:0]      start_adr;

    logic [31:0] tb_mem  [0:4095];
    logic [31:0] ref_mem [0:4095];

    int checks   = 0;
    int failures = 0;

    typedef struct {
        bit          we;
        logic [11:0] adr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
    } vec_t;
    vec_t tbl [6];

    iram_access_ctrl #(.ADR_W(ADR_W), .DRAIN_CYCLES(DRAIN)) dut (
        .clk(clk), .rst_n(rst_n), .mon_own(mon_own), .mon_valid(mon_valid),
        .mon_we(mon_we), .mon_adr(mon_adr), .mon_wdata(mon_wdata), .mon_run(mon_run),
        .mon_start_adr(mon_start_adr), .mon_ack(mon_ack), .mon_rdata(mon_rdata),
        .mon_granted(mon_granted), .i_ram_radr(i_ram_radr), .i_ram_rdata(i_ram_rdata),
        .i_ram_wadr(i_ram_wadr), .i_ram_wdata(i_ram_wdata), .i_ram_wen(i_ram_wen),
        .i_read_sel(i_read_sel), .cpu_stall(cpu_stall), .rst_pipe(rst_pipe),
        .cpu_start(cpu_start), .start_adr(start_adr)
    );

    always #5 clk = ~clk;

    // Synchronous instruction RAM seen by the DUT.
    always @(posedge clk) begin
        if (i_ram_wen) tb_mem[i_ram_wadr] <= i_ram_wdata;
        i_ram_rdata <= tb_mem[i_ram_radr];
    end

    function automatic logic [31:0] init_word(input int a);
        return (32'(a) * 32'h01010101) ^ 32'hA5A5A5A5;
    endfunction

    function automatic logic [127:0] all_outs();
        return 128'({mon_ack, mon_rdata, mon_granted, i_ram_radr, i_ram_wadr, i_ram_wdata,
                     i_ram_wen, i_read_sel, cpu_stall, rst_pipe, cpu_start, start_adr});
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic acquire(input string name);
        mon_own = 1'b1;
        for (int c = 1; c <= DRAIN + 1; c++) begin
            step();
            if (c == 1) check({name, "_stall"}, 128'(cpu_stall), 128'(1));
            if (c >= DRAIN) check({name, "_granted"}, 128'(mon_granted), 128'(c == DRAIN + 1));
        end
    endtask

    // Strobe one access and watch an 8-cycle window: ack latency/count, write pulse, read data.
    task automatic access(input string name, input bit we, input logic [11:0] adr,
                          input logic [31:0] wd, input logic [31:0] exp_rd,
                          input int hold, input int drop_at, output int rel_cyc);
        int lat = 0;
        int acks = 0;
        int wens = 0;
        logic [11:0] wa = '0;
        logic [31:0] wdat = '0;
        logic [31:0] rd = '0;
        rel_cyc   = 0;
        mon_valid = 1'b1;
        mon_we    = we;
        mon_adr   = adr;
        mon_wdata = wd;
        for (int c = 1; c <= 8; c++) begin
            step();
            if (c >= hold) mon_valid = 1'b0;
            if (mon_ack) begin
                acks++;
                if (lat == 0) begin
                    lat = c;
                    rd  = mon_rdata;
                end
            end
            if (i_ram_wen) begin
                wens++;
                wa   = i_ram_wadr;
                wdat = i_ram_wdata;
            end
            if (rst_pipe && rel_cyc == 0) rel_cyc = c;
            if (c == drop_at) mon_own = 1'b0;
        end
        check({name, "_ack_lat"}, 128'(lat), 128'(we ? 2 : 3));
        check({name, "_ack_cnt"}, 128'(acks), 128'(1));
        check({name, "_wen_cnt"}, 128'(wens), 128'(we ? 1 : 0));
        if (we) begin
            check({name, "_wadr"}, 128'(wa), 128'(adr));
            check({name, "_wdata"}, 128'(wdat), 128'(wd));
        end else begin
            check({name, "_rdata"}, 128'(rd), 128'(exp_rd));
        end
    endtask

    initial begin
        int rc;
        int acks;
        int bad;
        for (int i = 0; i < 4096; i++) begin
            tb_mem[i]  = init_word(i);
            ref_mem[i] = init_word(i);
        end
        tbl[0] = '{1'b1, 12'h010, 32'hDEADBEEF, 32'h0};
        tbl[1] = '{1'b0, 12'h010, 32'h0,        32'hDEADBEEF};
        tbl[2] = '{1'b1, 12'hFFF, 32'h12345678, 32'h0};
        tbl[3] = '{1'b0, 12'hFFF, 32'h0,        32'h12345678};
        tbl[4] = '{1'b0, 12'h000, 32'h0,        32'hA5A5A5A5};
        tbl[5] = '{1'b1, 12'h010, 32'h00000000, 32'h0};

        rst_n = 1'b0; mon_own = 1'b0; mon_valid = 1'b0; mon_we = 1'b0; mon_run = 1'b0;
        mon_adr = '0; mon_wdata = '0; mon_start_adr = '0;
        step();
        step();
        check("reset_outs", all_outs(), 128'(0));
        rst_n = 1'b1;
        step();
        check("idle_outs", all_outs(), 128'(0));

        // Grant: cpu_stall at +1, mon_granted at +DRAIN+1.
        mon_own = 1'b1;
        for (int c = 1; c <= DRAIN + 1; c++) begin
            step();
            check($sformatf("grant_stall_c%0d", c), 128'(cpu_stall), 128'(1));
            check($sformatf("grant_granted_c%0d", c), 128'(mon_granted), 128'(c == DRAIN + 1));
        end
        check("grant_read_sel", 128'(i_read_sel), 128'(1));

        for (int i = 0; i < 6; i++) begin
            access($sformatf("tbl%0d", i), tbl[i].we, tbl[i].adr, tbl[i].wdata,
                   tbl[i].exp_rdata, 1, 0, rc);
            if (tbl[i].we) ref_mem[tbl[i].adr] = tbl[i].wdata;
        end

        // Release without restart.
        mon_run = 1'b0;
        mon_own = 1'b0;
        step();
        check("rel_rst_pipe", 128'(rst_pipe), 128'(1));
        check("rel_cpu_start", 128'(cpu_start), 128'(0));
        check("rel_stall", 128'(cpu_stall), 128'(1));
        check("rel_read_sel", 128'(i_read_sel), 128'(0));
        step();
        check("rel_idle_stall", 128'(cpu_stall), 128'(0));
        check("rel_idle_rst_pipe", 128'(rst_pipe), 128'(0));

        // Strobe while IDLE is dropped.
        mon_valid = 1'b1; mon_we = 1'b1; mon_adr = 12'h005; mon_wdata = 32'h11111111;
        step();
        mon_valid = 1'b0;
        acks = 0;
        bad  = 0;
        for (int c = 0; c < 6; c++) begin
            if (mon_ack) acks++;
            if (i_ram_wen || mon_granted) bad++;
            step();
        end
        check("idle_valid_acks", 128'(acks), 128'(0));
        check("idle_valid_activity", 128'(bad), 128'(0));

        // Restart at 0x40.
        acquire("acq2");
        mon_run = 1'b1;
        mon_start_adr = 30'h0000_0040;
        mon_own = 1'b0;
        step();
        check("run_rst_pipe", 128'(rst_pipe), 128'(1));
        check("run_cpu_start", 128'(cpu_start), 128'(1));
        check("run_start_adr", 128'(start_adr), 128'(30'h40));
        step();
        check("run_idle_stall", 128'(cpu_stall), 128'(0));
        check("run_idle_start", 128'(cpu_start), 128'(0));

        // Abort in DRAIN at count 2; mon_run left high so a wrong REL would show a start pulse.
        mon_own = 1'b1;
        step();
        step();
        mon_own = 1'b0;
        bad = 0;
        for (int c = 0; c < 6; c++) begin
            step();
            if (rst_pipe || cpu_start || mon_granted) bad++;
        end
        check("abort_no_pulses", 128'(bad), 128'(0));
        check("abort_stall", 128'(cpu_stall), 128'(0));
        mon_run = 1'b0;

        // mon_valid held into ACC gives one ack only.
        acquire("acq3");
        access("valid_in_acc", 1'b1, 12'h020, 32'hCAFEF00D, 32'h0, 2, 0, rc);
        ref_mem[12'h020] = 32'hCAFEF00D;
        access("valid_in_acc_rb", 1'b0, 12'h020, 32'h0, ref_mem[12'h020], 1, 0, rc);

        for (int i = 0; i < 40; i++) begin
            bit          we;
            logic [11:0] adr;
            logic [31:0] wd;
            we  = 1'($urandom_range(0, 1));
            adr = ($urandom_range(0, 1) == 1) ? 12'($urandom_range(0, 7)) : 12'($urandom_range(0, 4095));
            wd  = $urandom;
            access($sformatf("rnd%0d", i), we, adr, wd, ref_mem[adr], 1, 0, rc);
            if (we) ref_mem[adr] = wd;
        end

        // Drop ownership while in RD: ack still arrives, REL the cycle after.
        access("drop_in_rd", 1'b0, 12'h020, 32'h0, ref_mem[12'h020], 1, 2, rc);
        check("drop_in_rd_rel_cyc", 128'(rc), 128'(4));

        // Async reset in RD.
        acquire("acq4");
        mon_valid = 1'b1; mon_we = 1'b0; mon_adr = 12'h010;
        step();
        mon_valid = 1'b0;
        step();
        rst_n = 1'b0;
        #1;
        check("rst_in_rd_outs", all_outs(), 128'(0));
        acks = 0;
        for (int c = 0; c < 3; c++) begin
            step();
            if (mon_ack) acks++;
        end
        check("rst_in_rd_no_ack", 128'(acks), 128'(0));
        rst_n = 1'b1;
        acquire("acq5");
        access("post_rst_wr", 1'b1, 12'h3A0, 32'h0BADF00D, 32'h0, 1, 0, rc);
        ref_mem[12'h3A0] = 32'h0BADF00D;
        access("post_rst_rd", 1'b0, 12'h3A0, 32'h0, ref_mem[12'h3A0], 1, 0, rc);
        mon_own = 1'b0;
        step();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end
endmodule
